// File: rtl/scan_controller.sv
// Multiplexed N-digit 7-segment scan controller with refresh prescaler,
// PWM brightness, per-digit enable, leading-zero blanking and frame-latched data.
module scan_controller #(
    parameter  int NUM_DIGITS = 8,
    parameter  int PRESCALE   = 1024,
    localparam int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [SEL_W-1:0]        seg_sel,
    output logic [3:0]              nibble,
    output logic                    frame_start
);

    localparam int SUB_N = PRESCALE / 16;
    localparam int SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;

    logic [SUB_W-1:0]        sub;
    logic [3:0]              phase;
    logic [SEL_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] data_q;

    logic                    sub_last;
    logic                    frame_edge;
    logic                    lit;
    logic                    all_zero;
    logic [NUM_DIGITS-1:0]   lz;
    logic [NUM_DIGITS-1:0]   anodes_d;

    assign sub_last   = (sub == SUB_W'(SUB_N - 1));
    assign frame_edge = (idx == '0) && (phase == 4'd0) && (sub == '0);

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        all_zero = 1'b1;
        lz       = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (data_q[4*i +: 4] == 4'd0);
            lz[i]    = blank_lz & all_zero & (i != 0);
        end
    end

    assign lit = digit_en[idx] && !lz[idx] && (phase <= brightness);

    always_comb begin
        anodes_d = '1;
        if (lit) begin
            anodes_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub         <= '0;
            phase       <= 4'd0;
            idx         <= '0;
            data_q      <= '0;
            anodes      <= '1;
            seg_sel     <= '0;
            nibble      <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            if (sub_last) begin
                sub   <= '0;
                phase <= phase + 4'd1;
                if (phase == 4'd15) begin
                    idx <= (idx == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end else begin
                sub <= sub + 1'b1;
            end

            // Display data only changes at frame boundaries so a frame never tears.
            if (frame_edge) begin
                data_q <= data;
            end

            anodes      <= anodes_d;
            seg_sel     <= idx;
            nibble      <= data_q[4*idx +: 4];
            frame_start <= frame_edge;
        end
    end

endmodule

// File: doc/scan_controller.md
Name: scan_controller

Overview:
Parametrised multiplexed 7-segment scan controller. It generalises the fixed 8-digit anode/select sequencer to N digits and adds several features: an internal refresh prescaler, per-digit enable, PWM brightness, leading-zero blanking, and a tear-free frame latch of the display data. It sits between the register-file/datapath display bus and the hex-to-7-seg decoder; its outputs drive board anodes directly.

Parameters:
NUM_DIGITS, 8, number of digits scanned; legal range 2..16.
PRESCALE, 1024, clk cycles per digit slot; must be a multiple of 16 and at least 16.
SEL_W, clog2(NUM_DIGITS), derived localparam; width of seg_sel.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
data  in  4*NUM_DIGITS  display nibbles; digit i = data[4i+3:4i]
digit_en  in  NUM_DIGITS  1 = digit i may light
brightness  in  4  anode on-time per slot = (brightness+1)/16
blank_lz  in  1  1 = blank leading zero digits
anodes  out  NUM_DIGITS  active-low anode drive, registered
seg_sel  out  SEL_W  index of digit currently in its slot, registered
nibble  out  4  data nibble for seg_sel, registered
frame_start  out  1  one-cycle pulse at start of digit-0 slot, registered

Behaviour:
- State registers:
  - sub: 0..PRESCALE/16-1
  - phase: 0..15
  - idx: 0..NUM_DIGITS-1
  - data_q: 4*NUM_DIGITS
- Reset (async, takes effect immediately): sub=0, phase=0, idx=0, data_q=0, anodes=all 1, seg_sel=0, nibble=0, frame_start=0.
- Counters:
  - sub increments every clk.
  - At sub terminal value: sub->0, phase+1.
  - At phase=15 and sub terminal: phase->0, idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
  - Every digit gets exactly PRESCALE cycles; frame length = NUM_DIGITS*PRESCALE cycles.
  - Scan order is digit 0 (anodes[0]) upward, and is fixed regardless of digit_en.
- Frame latch: data_q <= data on every clk edge where idx=0, phase=0, sub=0.
  - This includes the first edge after reset release.
  - data changes mid-frame never show until the next frame.
- Blanking: leading-zero blank lz[i] (i>=1) = blank_lz AND data_q digits i..NUM_DIGITS-1 all zero. Digit 0 is never LZ-blanked.
- Registered outputs (one-cycle latency from state), computed from the current state each clk:
  - seg_sel <= idx.
  - nibble <= data_q[4*idx+:4].
  - anodes <= all 1 except bit idx = 0 when digit_en[idx]=1 AND lz[idx]=0 AND phase <= brightness.
  - frame_start <= (idx=0 AND phase=0 AND sub=0).
- brightness=15 gives 100% duty within the slot; brightness=0 gives 1/16.
- brightness, digit_en and blank_lz are sampled live (not frame-latched); a change takes effect on the next output register update.
- At most one anode bit is low in any cycle. No output glitches between slots because all outputs are registered.
- Reset mid-frame returns to digit 0 with anodes dark, and the first frame re-latches data.
- Disabled digits still consume their slot (constant refresh rate); seg_sel and nibble still track idx.

Test Plan:
1. NUM_DIGITS=4, PRESCALE=32, brightness=15, digit_en=4'hF, blank_lz=0, data=16'h4321 → anodes sequence 1110,1101,1011,0111, each held 32 cycles; nibble 1,2,3,4; seg_sel 0..3; frame_start pulses every 128 cycles; anodes=1111 during rst.
2. Same setup, brightness=3 → each anode low for 8 cycles (phase 0..3), then high for 24 cycles of its 32-cycle slot.
3. data=16'h0050, blank_lz=1 → digits 3 and 2 anodes never go low; digits 1 (5) and 0 (0) light normally. With data=0, only digit 0 lights.
4. Change data from 16'h1111 to 16'h2222 during digit-1 slot → nibble stays 1 for the rest of the frame; 2 appears from the slot after the next frame_start.
5. digit_en=4'b1010 → anodes[0] and anodes[2] stay high; slot timing unchanged (frame still 128 cycles).
6. Assert rst mid digit-2 slot for 3 cycles → anodes=1111 and seg_sel=0 immediately (asynchronously). After release, frame_start pulses on the first post-release output update and digit 0 lights with freshly latched data.
